key_debounce_multi: RTL

- Parametrised multi-channel debouncer for the keypad/encoder front end of the microwave controller.
- Each channel synchronises one raw mechanical input and filters it to a clean level.
- Emits single-cycle press/release strobes and an optional hold-to-repeat strobe, so the timer-entry logic can auto-increment while a key is held.
- Supersedes the single-channel fixed-count debouncer: adds width/depth parameters, release detection, enable, and repeat mode.

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 161 ++++++++++++++++
 rtl/key_debounce_multi.sv | 72 +++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the keypad/encoder debouncer:
//   - ch_state_e : per-channel debounce FSM state, 2-bit encoding
//   - fits_width : elaboration-time range check for count parameters
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,  // settled low
    ST_DEB_PRESS   = 2'd1,  // qualifying a rising input
    ST_HELD        = 2'd2,  // settled high
    ST_DEB_RELEASE = 2'd3   // qualifying a falling input
  } ch_state_e;

  // True when value is at least 1 and representable in an unsigned
  // counter of the given width.
  function automatic bit fits_width(input int value, input int width);
    return (value >= 1) && (longint'(value) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounce lane: two-flop synchroniser, IDLE/DEB_PRESS/HELD/DEB_RELEASE
// filter FSM with a stability counter, and a hold-to-repeat timer.
//
// Ports
//   clk           : system clock, rising edge
//   clear_n       : asynchronous active-low reset, clears every flop
//   en            : filter enable; 0 freezes FSM/counter/timer, pulses read 0
//   btn_raw       : raw asynchronous key input, active-high
//   btn_level     : debounced level
//   press_pulse   : one-cycle strobe when the level goes 0->1
//   release_pulse : one-cycle strobe when the level goes 1->0
//   repeat_pulse  : one-cycle auto-repeat strobe while held
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 1000,
  parameter int REPEAT_EN     = 1,
  parameter int RPT_W         = 20,
  parameter int REPEAT_DELAY  = 50000,
  parameter int REPEAT_PERIOD = 10000
) (
  input  logic clk,
  input  logic clear_n,
  input  logic en,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [RPT_W-1:0] DELAY_MAX  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] PERIOD_MAX = RPT_W'(REPEAT_PERIOD);

  logic             sync_meta;
  logic             sync;
  ch_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [RPT_W-1:0] rpt_timer;
  logic             rpt_periodic;   // first repeat already issued

  logic [RPT_W-1:0] rpt_next;
  logic [RPT_W-1:0] rpt_limit;
  logic             rpt_hit;
  logic             rpt_run;
  logic             release_now;

  // Synchroniser keeps running while en = 0 so the filter resumes on a
  // fresh sample rather than a stale one.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  // NOTE: every combinational output is assigned on every pass, so no latch
  // can be inferred.
  always_comb begin
    release_now = (state == ST_DEB_RELEASE) && !sync && (cnt == STABLE_MAX);
    // Timer runs through bounces (DEB_RELEASE) but not on the edge that
    // returns to IDLE, so a release never coincides with a repeat.
    rpt_run     = (REPEAT_EN != 0) &&
                  ((state == ST_HELD) || (state == ST_DEB_RELEASE)) &&
                  !release_now;
    rpt_limit   = rpt_periodic ? PERIOD_MAX : DELAY_MAX;
    rpt_next    = rpt_timer + 1'b1;
    rpt_hit     = rpt_next == rpt_limit;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      rpt_timer     <= '0;
      rpt_periodic  <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (en) begin
        case (state)
          ST_IDLE: begin
            if (sync) begin
              state <= ST_DEB_PRESS;
              cnt   <= CNT_ONE;
            end
          end
          ST_DEB_PRESS: begin
            if (!sync) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (cnt == STABLE_MAX) begin
              state        <= ST_HELD;
              cnt          <= '0;
              btn_level    <= 1'b1;
              press_pulse  <= 1'b1;
              rpt_timer    <= '0;
              rpt_periodic <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_HELD: begin
            if (!sync) begin
              state <= ST_DEB_RELEASE;
              cnt   <= CNT_ONE;
            end
          end
          ST_DEB_RELEASE: begin
            if (sync) begin
              state <= ST_HELD;
              cnt   <= '0;
            end else if (release_now) begin
              state         <= ST_IDLE;
              cnt           <= '0;
              btn_level     <= 1'b0;
              release_pulse <= 1'b1;
              rpt_timer     <= '0;
              rpt_periodic  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase

        // rpt_run excludes the release edge and both DEB_PRESS branches,
        // so this never competes with the timer clears above.
        if (rpt_run) begin
          if (rpt_hit) begin
            repeat_pulse <= 1'b1;
            rpt_timer    <= '0;
            rpt_periodic <= 1'b1;
          end else begin
            rpt_timer <= rpt_next;
          end
        end
      end
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
// NUM_CH independent debounce lanes for the microwave keypad/encoder front
// end, with press/release/auto-repeat strobes and a global any-key-held flag.
//
// Ports
//   clk           : system clock, rising edge
//   clear_n       : asynchronous active-low reset
//   en            : filter enable (shared by all channels)
//   btn_raw       : [NUM_CH] raw asynchronous key inputs, active-high
//   btn_level     : [NUM_CH] debounced levels
//   press_pulse   : [NUM_CH] one-cycle 0->1 strobes
//   release_pulse : [NUM_CH] one-cycle 1->0 strobes
//   repeat_pulse  : [NUM_CH] one-cycle hold-to-repeat strobes
//   any_held      : OR of btn_level
// -----------------------------------------------------------------------------
module key_debounce_multi
  import debounce_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 1000,
  parameter int REPEAT_EN     = 1,
  parameter int RPT_W         = 20,
  parameter int REPEAT_DELAY  = 50000,
  parameter int REPEAT_PERIOD = 10000
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] btn_raw,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] repeat_pulse,
  output logic              any_held
);

  // Reject parameter sets the counters cannot represent.
  if (!fits_width(STABLE_CYCLES, CNT_W)) begin : g_bad_stable
    $error("STABLE_CYCLES must be in 1..2^CNT_W-1");
  end
  if (REPEAT_EN != 0 && !fits_width(REPEAT_DELAY, RPT_W)) begin : g_bad_delay
    $error("REPEAT_DELAY must be in 1..2^RPT_W-1");
  end
  if (REPEAT_EN != 0 && !fits_width(REPEAT_PERIOD, RPT_W)) begin : g_bad_period
    $error("REPEAT_PERIOD must be in 1..2^RPT_W-1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W         (CNT_W),
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_EN     (REPEAT_EN),
      .RPT_W         (RPT_W),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .clear_n       (clear_n),
      .en            (en),
      .btn_raw       (btn_raw[i]),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  assign any_held = |btn_level;

endmodule
